// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode and mux-select encodings for the multicycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_IF        = 4'd1,
    S_ID        = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_RD    = 4'd4,
    S_WB_LW     = 4'd5,
    S_MEM_WR    = 4'd6,
    S_EXEC_R    = 4'd7,
    S_WB_R      = 4'd8,
    S_BEQ       = 4'd9,
    S_JUMP      = 4'd10,
    S_JAL       = 4'd11,
    S_JR        = 4'd12,
    S_EXEC_ADDI = 4'd13,
    S_EXEC_SLTI = 4'd14,
    S_WB_I      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JR    = 6'b000110;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // alu_op values are also decoded by alu_controller
  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;
  localparam logic [1:0] ALU_OP_SLT  = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR    = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC     = 2'b10;

  localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_JAL, OP_JR, OP_ADDIU, OP_SLTI: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// rtl/mc_output_decoder.sv - combinational state to control-word decode
module mc_output_decoder
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   op_bad,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_ID: begin
        // branch target is precomputed into ALUOut for a possible beq
        ctrl.alu_src_b  = ALU_SRC_B_IMM_SH2;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.illegal_op = op_bad;
        ctrl.instr_done = op_bad;
      end
      S_MEM_ADR, S_EXEC_ADDI, S_EXEC_SLTI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = (state == S_EXEC_SLTI) ? ALU_OP_SLT : ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_WB_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MEM_TO_REG_MDR;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNC;
      end
      S_WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RD;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_SRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_SRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_SRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RA;
        ctrl.mem_to_reg = MEM_TO_REG_PC;
        ctrl.instr_done = 1'b1;
      end
      S_JR: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_SRC_RS;
        ctrl.instr_done = 1'b1;
      end
      S_WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = MEM_TO_REG_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-subset sequencer: state register, next state, pc_en
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   op_bad;

  assign op_bad = (state == S_ID) && !op_supported(opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF: state_nxt = S_ID;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEM_ADR;
          OP_RTYPE:     state_nxt = S_EXEC_R;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_J:         state_nxt = S_JUMP;
          OP_JAL:       state_nxt = S_JAL;
          OP_JR:        state_nxt = S_JR;
          OP_ADDIU:     state_nxt = S_EXEC_ADDI;
          OP_SLTI:      state_nxt = S_EXEC_SLTI;
          default:      state_nxt = S_IF;
        endcase
      end
      // IR is frozen after IF, so opcode is still valid here
      S_MEM_ADR:   state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    state_nxt = S_WB_LW;
      S_EXEC_R:    state_nxt = S_WB_R;
      S_EXEC_ADDI: state_nxt = S_WB_I;
      S_EXEC_SLTI: state_nxt = S_WB_I;
      default:     state_nxt = S_IF;
    endcase
  end

  mc_output_decoder u_dec (
    .state  (state),
    .op_bad (op_bad),
    .ctrl   (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_src        = ctrl.pc_src;
  assign alu_op        = ctrl.alu_op;
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = ctrl.illegal_op;
  assign pc_en         = ctrl.pc_write | (ctrl.pc_write_cond & zero);

endmodule
